video_source_mux: RTL and testbench
===================================

Name: video_source_mux

Overview:
Parametrised, registered N-way RGB source selector for the clk_rgb domain. It sits between the video sources (test pattern generators, frame-buffer readout) and dvi_tx, replacing the ad-hoc combinational switch case. The source change is committed only at a frame boundary and is followed by an optional black-out of whole frames, so the display never tears or shows partial frames. It also expands 1-bit (mono) sources to full-scale white/black and keeps sync/DE aligned with colour through a fixed pipeline.

Parameters:
NUM_SOURCES, 8, number of selectable sources (1..15)
COLOR_WIDTH, 8, bits per colour channel
SEL_WIDTH, 4, width of sel; must satisfy 2**SEL_WIDTH > NUM_SOURCES
BLANK_FRAMES, 2, whole frames of forced black after each committed switch (0 = none)
SYNC_POLARITY, 1'b0, active level of hs/vs (0 = negative)
MONO_MASK, '0 (NUM_SOURCES bits), bit i set = source i is 1-bit; only its src_r bit 0 is used

Ports:
clk_rgb  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
ce  in  1  clock enable; low = every register holds
sel  in  SEL_WIDTH  requested source, already synchronous to clk_rgb
src_r  in  NUM_SOURCES*COLOR_WIDTH  red of all sources, source i at [i*COLOR_WIDTH +: COLOR_WIDTH]
src_g  in  NUM_SOURCES*COLOR_WIDTH  green, same packing
src_b  in  NUM_SOURCES*COLOR_WIDTH  blue, same packing
hs_in, vs_in, de_in  in  1 each  timing from pixel_iterator, aligned with src_*
r, g, b  out  COLOR_WIDTH each  output colour
hs, vs, de  out  1 each  delayed timing
active_sel  out  SEL_WIDTH  currently committed source
switching  out  1  high while in BLANK state

Behaviour:
- Reset (async assert, sync release): r/g/b=0, de=0, hs=vs=~SYNC_POLARITY, active_sel=0, state=SHOW, blank_cnt=0, switching=0, vs_prev=~SYNC_POLARITY.
- Latency: exactly 2 clk_rgb (ce-high) cycles from inputs to r/g/b/hs/vs/de. hs/vs/de are delayed with no modification.
- Stage 1: register hs/vs/de and the colour of source active_sel. If active_sel >= NUM_SOURCES, colour = 0. If MONO_MASK[active_sel] is set, all three channels = {COLOR_WIDTH{src_r[active_sel*COLOR_WIDTH]}}.
- Stage 2: colour forced to 0 when stage-1 de=0 or state=BLANK; otherwise pass through.
- Frame boundary (fb): a one-cycle pulse when vs_in goes from inactive to active (vs_prev != SYNC_POLARITY && vs_in == SYNC_POLARITY). vs_prev updates on every ce cycle.
- State machine, evaluated only on fb:
  - SHOW, sel != active_sel: active_sel <= sel. If BLANK_FRAMES>0, go to BLANK with blank_cnt=BLANK_FRAMES; otherwise stay in SHOW.
  - SHOW, sel == active_sel: no change.
  - BLANK, sel != active_sel: commit the new sel and reload blank_cnt=BLANK_FRAMES. Stay in BLANK.
  - BLANK, otherwise: blank_cnt-1. On reaching 0, go to SHOW.
- sel changes between boundaries are ignored until the next fb. Only the value present on the fb cycle counts, so glitches mid-frame have no effect.
- An active_sel change takes effect in stage 1 on the cycle after fb. This is within vertical sync, so de=0 and no visible pixel is affected.
- ce low: no state, counter, vs_prev or pipeline update. An fb cannot be detected while ce=0.
- Reset mid-BLANK: returns to SHOW with source 0 immediately.
- blank_cnt width is $clog2(BLANK_FRAMES+1), minimum 1.

Test Plan:
- Reset release, sel=0, source 0 = 8'hAA all channels, de_in=1 pulse -> r=g=b=8'hAA exactly 2 cycles after the de_in pulse; hs/vs/de match inputs delayed by 2.
- sel 0->3 mid-frame, BLANK_FRAMES=2 -> active_sel stays 0 until the next vs_in active edge. Then active_sel=3, switching=1 and output black for 2 full frames. Source 3 colour appears on the first active pixel of the 3rd frame.
- BLANK_FRAMES=0, sel 1->2 -> at fb active_sel=2, switching never asserts, next frame shows source 2.
- MONO_MASK[6]=1, sel=6, src_r[48]=1 then 0 -> r=g=b=8'hFF then 8'h00, regardless of src_g/src_b contents.
- sel=12 with NUM_SOURCES=8 -> after fb and blanking, output r=g=b=0 with de still toggling; returning sel=1 recovers after BLANK_FRAMES frames.
- ce held low 10 cycles, with an fb edge occurring while ce=0 -> outputs frozen, no commit. Async rst asserted during BLANK -> immediate active_sel=0, switching=0, r/g/b=0.

Source files
------------

// File: rtl/video_source_mux.sv
// video_source_mux
//   Registered N-way RGB source selector for the clk_rgb domain. A new source
//   is committed only on a frame boundary, which is the inactive-to-active edge
//   of vs_in. After the commit, the output can be forced to black for
//   BLANK_FRAMES whole frames. Mono (1-bit) sources are expanded to full-scale
//   white or black. Timing signals travel through the same 2-stage pipeline as
//   the colour, so sync and DE stay aligned with it.
//
// Ports
//   clk_rgb               pixel clock
//   rst                   asynchronous active-high reset
//   ce                    clock enable; when low, every register holds
//   sel                   requested source, synchronous to clk_rgb
//   src_r/src_g/src_b     packed colour of all sources; source i sits at
//                         [i*COLOR_WIDTH +: COLOR_WIDTH]
//   hs_in/vs_in/de_in     timing aligned with src_*
//   r/g/b                 output colour, 2 cycles after the inputs
//   hs/vs/de              timing delayed by 2 cycles, otherwise unmodified
//   active_sel            currently committed source
//   switching             high while black-out frames are in progress
module video_source_mux #(
    parameter int                     NUM_SOURCES   = 8,
    parameter int                     COLOR_WIDTH   = 8,
    parameter int                     SEL_WIDTH     = 4,
    parameter int                     BLANK_FRAMES  = 2,
    parameter logic                   SYNC_POLARITY = 1'b0,
    parameter logic [NUM_SOURCES-1:0] MONO_MASK     = '0
) (
    input  logic                               clk_rgb,
    input  logic                               rst,
    input  logic                               ce,
    input  logic [SEL_WIDTH-1:0]               sel,
    input  logic [NUM_SOURCES*COLOR_WIDTH-1:0] src_r,
    input  logic [NUM_SOURCES*COLOR_WIDTH-1:0] src_g,
    input  logic [NUM_SOURCES*COLOR_WIDTH-1:0] src_b,
    input  logic                               hs_in,
    input  logic                               vs_in,
    input  logic                               de_in,
    output logic [COLOR_WIDTH-1:0]             r,
    output logic [COLOR_WIDTH-1:0]             g,
    output logic [COLOR_WIDTH-1:0]             b,
    output logic                               hs,
    output logic                               vs,
    output logic                               de,
    output logic [SEL_WIDTH-1:0]               active_sel,
    output logic                               switching
);

    localparam int CNT_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BLANK_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    // Frame-level control
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       blank_cnt_q, blank_cnt_d;
    logic [SEL_WIDTH-1:0]   active_sel_q, active_sel_d;
    logic                   vs_prev_q;
    logic                   fb;

    // Pipeline stage 1
    logic                   hs1_q, vs1_q, de1_q;
    logic                   hs1_d, vs1_d, de1_d;
    logic [COLOR_WIDTH-1:0] r1_q, g1_q, b1_q;
    logic [COLOR_WIDTH-1:0] r1_d, g1_d, b1_d;

    // Pipeline stage 2 (outputs)
    logic                   hs2_q, vs2_q, de2_q;
    logic [COLOR_WIDTH-1:0] r2_q, g2_q, b2_q;
    logic [COLOR_WIDTH-1:0] r2_d, g2_d, b2_d;

    // An edge is only seen when ce is high, because vs_prev_q is sampled
    // only on ce cycles.
    assign fb = ce && (vs_prev_q != SYNC_POLARITY) && (vs_in == SYNC_POLARITY);

    // Next-state logic, evaluated only on frame boundaries
    always_comb begin
        state_d      = state_q;
        blank_cnt_d  = blank_cnt_q;
        active_sel_d = active_sel_q;
        if (fb) begin
            case (state_q)
                ST_SHOW: begin
                    if (sel != active_sel_q) begin
                        active_sel_d = sel;
                        if (BLANK_FRAMES > 0) begin
                            state_d     = ST_BLANK;
                            blank_cnt_d = CNT_RELOAD;
                        end
                    end
                end
                ST_BLANK: begin
                    if (sel != active_sel_q) begin
                        // A request that arrives mid-blank restarts the black-out.
                        active_sel_d = sel;
                        blank_cnt_d  = CNT_RELOAD;
                    end else begin
                        blank_cnt_d = blank_cnt_q - CNT_ONE;
                        if (blank_cnt_q == CNT_ONE) begin
                            state_d = ST_SHOW;
                        end
                    end
                end
                default: begin
                    state_d     = ST_SHOW;
                    blank_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SHOW;
            blank_cnt_q  <= '0;
            active_sel_q <= '0;
            vs_prev_q    <= ~SYNC_POLARITY;
        end else if (ce) begin
            state_q      <= state_d;
            blank_cnt_q  <= blank_cnt_d;
            active_sel_q <= active_sel_d;
            vs_prev_q    <= vs_in;
        end
    end

    // Stage 1: select the colour of the committed source. A selection that is
    // out of range matches no source, so it yields black.
    always_comb begin
        hs1_d = hs_in;
        vs1_d = vs_in;
        de1_d = de_in;
        r1_d  = '0;
        g1_d  = '0;
        b1_d  = '0;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            if (active_sel_q == SEL_WIDTH'(i)) begin
                if (MONO_MASK[i]) begin
                    r1_d = {COLOR_WIDTH{src_r[i*COLOR_WIDTH]}};
                    g1_d = {COLOR_WIDTH{src_r[i*COLOR_WIDTH]}};
                    b1_d = {COLOR_WIDTH{src_r[i*COLOR_WIDTH]}};
                end else begin
                    r1_d = src_r[i*COLOR_WIDTH +: COLOR_WIDTH];
                    g1_d = src_g[i*COLOR_WIDTH +: COLOR_WIDTH];
                    b1_d = src_b[i*COLOR_WIDTH +: COLOR_WIDTH];
                end
            end
        end
    end

    // Stage 2: black outside the active area and during the black-out frames
    always_comb begin
        r2_d = '0;
        g2_d = '0;
        b2_d = '0;
        if (de1_q && (state_q == ST_SHOW)) begin
            r2_d = r1_q;
            g2_d = g1_q;
            b2_d = b1_q;
        end
    end

    always_ff @(posedge clk_rgb or posedge rst) begin
        if (rst) begin
            hs1_q <= ~SYNC_POLARITY;
            vs1_q <= ~SYNC_POLARITY;
            de1_q <= 1'b0;
            r1_q  <= '0;
            g1_q  <= '0;
            b1_q  <= '0;
            hs2_q <= ~SYNC_POLARITY;
            vs2_q <= ~SYNC_POLARITY;
            de2_q <= 1'b0;
            r2_q  <= '0;
            g2_q  <= '0;
            b2_q  <= '0;
        end else if (ce) begin
            hs1_q <= hs1_d;
            vs1_q <= vs1_d;
            de1_q <= de1_d;
            r1_q  <= r1_d;
            g1_q  <= g1_d;
            b1_q  <= b1_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            de2_q <= de1_q;
            r2_q  <= r2_d;
            g2_q  <= g2_d;
            b2_q  <= b2_d;
        end
    end

    assign r          = r2_q;
    assign g          = g2_q;
    assign b          = b2_q;
    assign hs         = hs2_q;
    assign vs         = vs2_q;
    assign de         = de2_q;
    assign active_sel = active_sel_q;
    assign switching  = (state_q == ST_BLANK);

endmodule

// File: tb/tb_video_source_mux.sv
module tb_video_source_mux;

    localparam int           N  = 8;
    localparam int           CW = 8;
    localparam int           SW = 4;
    localparam logic         SP = 1'b0;
    localparam logic [N-1:0] MM = 8'h40;
    localparam int           FRAME = 96;   // 16 pixels x 6 lines

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
    } pix_t;

    logic            clk_rgb = 1'b0;
    logic            rst;
    logic            ce;
    logic [SW-1:0]   sel;
    logic [N*CW-1:0] src_r, src_g, src_b;
    logic            hs_in, vs_in, de_in;

    logic [CW-1:0] a_r, a_g, a_b, z_r, z_g, z_b;
    logic          a_hs, a_vs, a_de, a_sw, z_hs, z_vs, z_de, z_sw;
    logic [SW-1:0] a_act, z_act;

    always #5 clk_rgb = ~clk_rgb;

    // Instance A: default black-out of 2 frames
    video_source_mux #(
        .NUM_SOURCES(N), .COLOR_WIDTH(CW), .SEL_WIDTH(SW),
        .BLANK_FRAMES(2), .SYNC_POLARITY(SP), .MONO_MASK(MM)
    ) dut_a (
        .clk_rgb(clk_rgb), .rst(rst), .ce(ce), .sel(sel),
        .src_r(src_r), .src_g(src_g), .src_b(src_b),
        .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .r(a_r), .g(a_g), .b(a_b), .hs(a_hs), .vs(a_vs), .de(a_de),
        .active_sel(a_act), .switching(a_sw)
    );

    // Instance Z: no black-out
    video_source_mux #(
        .NUM_SOURCES(N), .COLOR_WIDTH(CW), .SEL_WIDTH(SW),
        .BLANK_FRAMES(0), .SYNC_POLARITY(SP), .MONO_MASK(MM)
    ) dut_z (
        .clk_rgb(clk_rgb), .rst(rst), .ce(ce), .sel(sel),
        .src_r(src_r), .src_g(src_g), .src_b(src_b),
        .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .r(z_r), .g(z_g), .b(z_b), .hs(z_hs), .vs(z_vs), .de(z_de),
        .active_sel(z_act), .switching(z_sw)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model, kept at the frame level:
    //   cur    = committed source
    //   left   = black frames still owed
    //   s1/out = pixel records in flight
    int   bf   [2] = '{2, 0};
    int   cur  [2];
    int   left [2];
    pix_t s1_m [2];
    pix_t out_m[2];
    logic vs_prev_m;

    // Video timing generator state and stimulus controls
    int   h = 0;
    int   v = 0;
    logic fix_aa  = 1'b0;
    logic ce_rand = 1'b0;

    function automatic logic [3*CW-1:0] pick(int s);
        logic [CW-1:0] m;
        if (s >= N) return '0;
        if (MM[s]) begin
            m = {CW{src_r[s*CW]}};
            return {m, m, m};
        end
        return {src_r[s*CW +: CW], src_g[s*CW +: CW], src_b[s*CW +: CW]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            cur[k]   = 0;
            left[k]  = 0;
            s1_m[k]  = {~SP, ~SP, 1'b0, {3*CW{1'b0}}};
            out_m[k] = {~SP, ~SP, 1'b0, {3*CW{1'b0}}};
        end
        vs_prev_m = ~SP;
    endtask

    task automatic model_edge();
        logic fbm;
        if (rst) begin
            model_reset();
            return;
        end
        if (!ce) return;
        fbm = (vs_prev_m != SP) && (vs_in == SP);
        for (int k = 0; k < 2; k++) begin
            out_m[k] = s1_m[k];
            if (!(s1_m[k].de && left[k] == 0)) begin
                out_m[k].r = '0;
                out_m[k].g = '0;
                out_m[k].b = '0;
            end
            s1_m[k] = {hs_in, vs_in, de_in, pick(cur[k])};
            if (fbm) begin
                if (int'(sel) != cur[k]) begin
                    cur[k]  = int'(sel);
                    left[k] = bf[k];
                end else if (left[k] > 0) begin
                    left[k] = left[k] - 1;
                end
            end
        end
        vs_prev_m = vs_in;
    endtask

    task automatic check(string tag);
        logic [31:0] ea, ez, oa, oz;
        ea = {out_m[0].r, out_m[0].g, out_m[0].b, out_m[0].hs, out_m[0].vs, out_m[0].de,
              SW'(cur[0]), (left[0] > 0)};
        ez = {out_m[1].r, out_m[1].g, out_m[1].b, out_m[1].hs, out_m[1].vs, out_m[1].de,
              SW'(cur[1]), (left[1] > 0)};
        oa = {a_r, a_g, a_b, a_hs, a_vs, a_de, a_act, a_sw};
        oz = {z_r, z_g, z_b, z_hs, z_vs, z_de, z_act, z_sw};
        checks++;
        assert (oa === ea) else begin
            errors++;
            $error("FAIL %s dutA cyc=%0d observed=%h expected=%h", tag, cyc, oa, ea);
        end
        checks++;
        assert (oz === ez) else begin
            errors++;
            $error("FAIL %s dutZ cyc=%0d observed=%h expected=%h", tag, cyc, oz, ez);
        end
    endtask

    // Drive one pixel of a 16x6 raster: 10x4 active pixels, hs at pixels
    // 12-13, vs on line 5. Colours are random each pixel.
    task automatic drive();
        de_in = (h < 10) && (v < 4);
        hs_in = (h >= 12 && h < 14) ? SP : ~SP;
        vs_in = (v == 5) ? SP : ~SP;
        for (int i = 0; i < N; i++) begin
            src_r[i*CW +: CW] = CW'($urandom);
            src_g[i*CW +: CW] = CW'($urandom);
            src_b[i*CW +: CW] = CW'($urandom);
        end
        if (fix_aa) begin
            src_r[0 +: CW] = 8'hAA;
            src_g[0 +: CW] = 8'hAA;
            src_b[0 +: CW] = 8'hAA;
        end
        if (ce_rand) ce = ($urandom_range(0, 7) != 0);
        h++;
        if (h == 16) begin
            h = 0;
            v = (v == 5) ? 0 : v + 1;
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk_rgb);
        model_edge();
        #1;
        cyc++;
        check(tag);
        drive();
    endtask

    task automatic run(int n, string tag);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    task automatic wait_pos(int vv, int hh);
        int k;
        k = 0;
        while (!(v == vv && h == hh) && k < 200) begin
            tick("wait");
            k++;
        end
        checks++;
        assert (k < 200) else begin
            errors++;
            $error("FAIL wait_pos observed=timeout required=v%0d h%0d", vv, hh);
        end
    endtask

    initial begin
        rst = 1'b0;
        ce  = 1'b1;
        sel = '0;
        drive();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("reset");
        run(3, "in_reset");
        rst = 1'b0;

        // Source 0 at constant AA: colour and timing arrive 2 cycles late
        fix_aa = 1'b1;
        run(2 * FRAME, "latency");
        fix_aa = 1'b0;

        // Mid-frame request 0->3: commit at the next vs edge, then blank
        wait_pos(1, 5);
        sel = 4'd3;
        run(4 * FRAME, "sel3");

        // Requests 1->2 (Z switches without blanking)
        sel = 4'd1;
        run(3 * FRAME, "sel1");
        sel = 4'd2;
        run(3 * FRAME, "sel2");

        // Mono source 6
        sel = 4'd6;
        run(3 * FRAME, "mono6");

        // Out-of-range source, then recovery
        sel = 4'd12;
        run(4 * FRAME, "sel12");
        sel = 4'd1;
        run(4 * FRAME, "recover1");

        // ce low for 10 cycles with a vs edge inside the window
        wait_pos(4, 10);
        sel = 4'd5;
        ce  = 1'b0;
        run(10, "ce_low");
        ce = 1'b1;
        run(2 * FRAME, "ce_back");

        // Random selects, including mid-frame glitches and random ce
        ce_rand = 1'b1;
        for (int k = 0; k < 20 * FRAME; k++) begin
            if ($urandom_range(0, 39) == 0) sel = SW'($urandom_range(0, 15));
            tick("random");
        end
        ce_rand = 1'b0;
        ce      = 1'b1;

        // Asynchronous reset while blanking
        sel = (a_act == 4'd4) ? 4'd7 : 4'd4;
        for (int k = 0; k < 400 && !(left[0] > 0); k++) tick("to_blank");
        run(20, "in_blank");
        checks++;
        assert (a_sw === 1'b1) else begin
            errors++;
            $error("FAIL blank_reached observed=%b required=1", a_sw);
        end
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst");
        run(2, "rst_hold");
        rst = 1'b0;
        run(FRAME, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
